// File: rtl/regs_wr_arb.sv
// Round-robin write arbiter for a register bank: grants one of REQ_N requesters,
// then drives a one-cycle one-hot WE/CLR strobe, write data and ACK to the winner.
module regs_wr_arb #(
    parameter int REQ_N  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [REQ_N-1:0]          REQ,
    input  logic [REQ_N-1:0]          CLR_REQ,
    input  logic [REQ_N*ADDR_W-1:0]   ADDR,
    input  logic [REQ_N*DATA_W-1:0]   WDATA,
    output logic [REQ_N-1:0]          ACK,
    output logic [(2**ADDR_W)-1:0]    WE_O,
    output logic [(2**ADDR_W)-1:0]    CLR_O,
    output logic [DATA_W-1:0]         PDI_O,
    output logic                      BUSY
);

    localparam int REG_N = 2**ADDR_W;
    localparam int IDX_W = $clog2(REQ_N);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   grant;
    logic               grant_valid;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;
    logic               grant_clr;

    logic [REQ_N-1:0]   ack_d;
    logic [REG_N-1:0]   we_d;
    logic [REG_N-1:0]   clr_d;
    logic [DATA_W-1:0]  pdi_d;

    // Rotating priority: first requester set at or after last+1, wrapping.
    always_comb begin
        grant       = last;
        grant_valid = 1'b0;
        for (int k = 1; k <= REQ_N; k++) begin
            if (!grant_valid && REQ[(int'(last) + k) % REQ_N]) begin
                grant_valid = 1'b1;
                grant       = IDX_W'((int'(last) + k) % REQ_N);
            end
        end
    end

    assign grant_addr = ADDR[int'(grant)*ADDR_W +: ADDR_W];
    assign grant_data = WDATA[int'(grant)*DATA_W +: DATA_W];
    assign grant_clr  = CLR_REQ[grant];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            last  <= IDX_W'(REQ_N - 1);
            ACK   <= '0;
            WE_O  <= '0;
            CLR_O <= '0;
            PDI_O <= '0;
            BUSY  <= 1'b0;
        end else begin
            state <= next_state;
            ACK   <= ack_d;
            WE_O  <= we_d;
            CLR_O <= clr_d;
            PDI_O <= pdi_d;
            BUSY  <= (next_state == WRITE);
            if (state == IDLE && grant_valid) begin
                last <= grant;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Values loaded into the output flops; non-zero only for the cycle entering WRITE.
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        ack_d = '0;
        we_d  = '0;
        clr_d = '0;
        pdi_d = '0;
        if (state == IDLE && grant_valid) begin
            ack_d[grant]     = 1'b1;
            we_d[grant_addr] = 1'b1;
            if (grant_clr) begin
                clr_d[grant_addr] = 1'b1;
            end else begin
                pdi_d = grant_data;
            end
        end
    end

endmodule
